// File: rtl/motor_cmd_queue.sv
// motor_cmd_queue: validated motor command FIFO feeding Control.
// Releases one command per completed move once calibration is done.
module motor_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              CmdValid,
  input  logic [5:0]        CmdMotor,
  input  logic [3:0]        CmdT0,
  input  logic [3:0]        CmdT1,
  input  logic [3:0]        CmdT2,
  output logic              CmdReady,
  input  logic              INIT,
  input  logic              Busy,
  output logic [5:0]        Motor,
  output logic [3:0]        TValue0,
  output logic [3:0]        TValue1,
  output logic [3:0]        TValue2,
  output logic              Issue,
  output logic              CmdErr,
  output logic [ADDR_W:0]   Level
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, RUN, GAP
  } state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [17:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   level_q;
  logic [CW-1:0]     cnt_q;
  logic [5:0]        motor_q;
  logic [3:0]        t0_q, t1_q, t2_q;
  logic              err_q;
  state_t            state_q, state_d;
  logic              onehot, digits_ok;
  logic              push, pop, timeout;

  assign onehot = (CmdMotor != 6'd0) &&
                  ((CmdMotor & (CmdMotor - 6'd1)) == 6'd0);
  assign digits_ok = (CmdT0 <= 4'd9) && (CmdT1 <= 4'd9) &&
                     (CmdT2 <= 4'd9);

  assign CmdReady = (level_q != (ADDR_W+1)'(DEPTH));
  assign push     = CmdValid && CmdReady && onehot && digits_ok;
  assign pop      = (state_q == IDLE) && INIT && (level_q != '0);
  assign timeout  = (cnt_q == CW'(ACK_TIMEOUT - 1));

  assign Level   = level_q;
  assign CmdErr  = err_q;
  assign TValue0 = t0_q;
  assign TValue1 = t1_q;
  assign TValue2 = t2_q;

  // FIFO storage; contents need no reset, occupancy guards reads
  always_ff @(posedge sysclk) begin
    if (push) mem[wptr] <= {CmdMotor, CmdT0, CmdT1, CmdT2};
  end

  // Pointers and occupancy
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)
        level_q <= level_q + 1'b1;
      else if (pop && !push)
        level_q <= level_q - 1'b1;
    end
  end

  // Active command registers, reject strobe and ack timer
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      motor_q <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= CmdValid && !push;
      if (pop) {motor_q, t0_q, t1_q, t2_q} <= mem[rptr];
      if (state_q == ISSUE)
        cnt_q <= '0;
      else if (state_q == WAIT_ACK)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // State register
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and strobes; Motor drops to 0 outside an active move
  always_comb begin
    state_d = state_q;
    Issue   = 1'b0;
    Motor   = '0;
    unique case (state_q)
      IDLE: begin
        if (INIT && level_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        Issue   = 1'b1;
        Motor   = motor_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        Motor = motor_q;
        if (!INIT)        state_d = GAP;
        else if (Busy)    state_d = RUN;
        else if (timeout) state_d = GAP;
      end
      RUN: begin
        Motor = motor_q;
        if (!INIT || !Busy) state_d = GAP;
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_motor_cmd_queue.sv
// tb_motor_cmd_queue: scoreboard bench for motor_cmd_queue.
// Accepted pushes queue expected issues; a monitor checks each Issue.
module tb_motor_cmd_queue;

  typedef struct packed {
    logic [5:0] m;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [3:0] t2;
  } cmd_t;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       CmdValid;
  logic [5:0] CmdMotor;
  logic [3:0] CmdT0, CmdT1, CmdT2;
  logic       CmdReady;
  logic       INIT, Busy;
  logic [5:0] Motor;
  logic [3:0] TValue0, TValue1, TValue2;
  logic       Issue, CmdErr;
  logic [2:0] Level;

  cmd_t exp_q[$];
  cmd_t e;
  int   vec = 0;
  int   bad = 0;
  int   issues = 0;

  always #5 sysclk = ~sysclk;

  motor_cmd_queue dut (
    .sysclk(sysclk), .rst(rst),
    .CmdValid(CmdValid), .CmdMotor(CmdMotor),
    .CmdT0(CmdT0), .CmdT1(CmdT1), .CmdT2(CmdT2),
    .CmdReady(CmdReady), .INIT(INIT), .Busy(Busy),
    .Motor(Motor), .TValue0(TValue0),
    .TValue1(TValue1), .TValue2(TValue2),
    .Issue(Issue), .CmdErr(CmdErr), .Level(Level)
  );

  task automatic chk(input string n, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // monitor: every Issue strobe must match the oldest expected command
  always @(negedge sysclk) begin
    if (rst && Issue) begin
      issues++;
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_cmd", int'({Motor, TValue0, TValue1, TValue2}),
            int'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [5:0] m, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c,
                      input bit ok);
    cmd_t x;
    x = {m, a, b, c};
    if (ok) exp_q.push_back(x);
    CmdValid = 1'b1;
    CmdMotor = m;
    CmdT0 = a;
    CmdT1 = b;
    CmdT2 = c;
    tick(1);
    CmdValid = 1'b0;
  endtask

  task automatic wait_issue(input int target);
    int n;
    n = 0;
    while (issues < target && n < 200) begin
      tick(1);
      n++;
    end
    chk("issue_wait", int'(issues >= target), 1);
  endtask

  task automatic run_move(input int target);
    wait_issue(target);
    Busy = 1'b1;
    tick(6);
    chk("hold_while_busy", issues, target);
    Busy = 1'b0;
    tick(1);
    chk("gap_motor", Motor, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst = 1'b0;
    CmdValid = 1'b0;
    CmdMotor = '0;
    CmdT0 = '0;
    CmdT1 = '0;
    CmdT2 = '0;
    INIT = 1'b0;
    Busy = 1'b0;
    tick(3);
    chk("rst_level", Level, 0);
    chk("rst_ready", CmdReady, 1);
    chk("rst_motor", Motor, 0);
    chk("rst_tval", int'({TValue0, TValue1, TValue2}), 0);
    chk("rst_issue", Issue, 0);
    chk("rst_err", CmdErr, 0);
    rst = 1'b1;
    tick(2);

    // single command, long busy
    INIT = 1'b1;
    push(6'b000010, 4'd0, 4'd1, 4'd0, 1'b1);
    chk("t1_level", Level, 1);
    chk("t1_noissue", Issue, 0);
    tick(1);
    chk("t1_issue", Issue, 1);
    chk("t1_motor", Motor, 2);
    chk("t1_tv1", TValue1, 1);
    chk("t1_level0", Level, 0);
    Busy = 1'b1;
    tick(1);
    chk("t1_strobe1", Issue, 0);
    tick(100);
    chk("t1_held", Motor, 2);
    Busy = 1'b0;
    tick(1);
    chk("t1_gap", Motor, 0);
    tick(1);
    chk("t1_idle_motor", Motor, 0);
    chk("t1_idle_issue", Issue, 0);
    chk("t1_tv_held", TValue1, 1);

    // fill while uncalibrated, then drain in order
    INIT = 1'b0;
    base = issues;
    push(6'b000001, 4'd1, 4'd2, 4'd3, 1'b1);
    push(6'b000100, 4'd9, 4'd9, 4'd9, 1'b1);
    push(6'b100000, 4'd0, 4'd0, 4'd0, 1'b1);
    push(6'b010000, 4'd4, 4'd5, 4'd6, 1'b1);
    chk("t2_level4", Level, 4);
    chk("t2_notready", CmdReady, 0);
    push(6'b001000, 4'd1, 4'd1, 4'd1, 1'b0);
    chk("t2_full_err", CmdErr, 1);
    tick(1);
    chk("t2_err_1cyc", CmdErr, 0);
    chk("t2_level_kept", Level, 4);
    tick(5);
    chk("t2_no_issue", issues, base);
    INIT = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      run_move(base + k);
      chk("t2_level", Level, 4 - k);
    end
    tick(3);
    chk("t2_drained", exp_q.size(), 0);

    // malformed commands
    push(6'b000011, 4'd0, 4'd0, 4'd1, 1'b0);
    chk("t3_onehot_err", CmdErr, 1);
    push(6'b000001, 4'd0, 4'd0, 4'd10, 1'b0);
    chk("t3_bcd_err", CmdErr, 1);
    tick(1);
    chk("t3_err_clr", CmdErr, 0);
    chk("t3_level", Level, 0);

    // identical commands, no busy: both time out
    base = issues;
    push(6'b000001, 4'd0, 4'd0, 4'd5, 1'b1);
    push(6'b000001, 4'd0, 4'd0, 4'd5, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      wait_issue(base + k);
      chk("t4_level", Level, 2 - k);
      n = 0;
      while (Motor != 6'd0 && n < 40) begin
        tick(1);
        n++;
      end
      chk("t4_timeout_len", n, 16);
    end

    // calibration lost mid-move
    tick(3);
    base = issues;
    push(6'b000100, 4'd1, 4'd0, 4'd0, 1'b1);
    push(6'b001000, 4'd2, 4'd0, 4'd0, 1'b1);
    push(6'b010000, 4'd3, 4'd0, 4'd0, 1'b1);
    wait_issue(base + 1);
    Busy = 1'b1;
    tick(1);
    chk("t5_level2", Level, 2);
    tick(3);
    INIT = 1'b0;
    tick(1);
    chk("t5_gap", Motor, 0);
    Busy = 1'b0;
    tick(10);
    chk("t5_no_issue", issues, base + 1);
    chk("t5_level_kept", Level, 2);
    INIT = 1'b1;
    wait_issue(base + 2);
    chk("t5_level1", Level, 1);

    // reset during a move with 3 queued
    Busy = 1'b1;
    tick(2);
    push(6'b100000, 4'd7, 4'd0, 4'd0, 1'b1);
    push(6'b000010, 4'd8, 4'd0, 4'd0, 1'b1);
    chk("t6_level3", Level, 3);
    chk("t6_running", Motor, 8);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_motor", Motor, 0);
    chk("t6_tval", int'({TValue0, TValue1, TValue2}), 0);
    chk("t6_level", Level, 0);
    chk("t6_ready", CmdReady, 1);
    chk("t6_issue", Issue, 0);
    tick(2);
    rst = 1'b1;
    Busy = 1'b0;
    base = issues;
    tick(6);
    chk("t6_level_after", Level, 0);
    chk("t6_no_issue", issues, base);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
